instr_loader: RTL

Program loader that writes the instruction memory read by the fetch stage. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. Each word is written to consecutive instruction-memory addresses from a latched base address. The core is held in reset via `core_hold` until a frame loads with a correct checksum, after which the fetch stage may start executing from PC 0.

---
 rtl/instr_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - Framed byte-stream loader that writes big-endian 16-bit words into instruction memory.
// Holds the core in reset until a frame with a matching XOR checksum has been loaded.
module instr_loader #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nx;
  logic [15:0]       len;
  logic [7:0]        hi_byte;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] wr_addr;
  logic              start_ok;
  logic              accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // in_ready depends on the state register only, never on in_valid.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    start_ok = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        start_ok = start;
        if (start) state_nx = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ({len[15:8], in_data} == 16'd0) ? S_CSUM : S_DATA_HI;
      end
      S_DATA_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_DATA_LO;
      end
      S_DATA_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (word_cnt == len - 16'd1) ? S_CSUM : S_DATA_HI;
      end
      S_CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (in_data == csum) ? S_DONE : S_ERR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_hold <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= '0;
      len       <= '0;
      hi_byte   <= '0;
      csum      <= '0;
      wr_addr   <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        wr_addr   <= base_addr;
        word_cnt  <= '0;
        csum      <= '0;
        done      <= 1'b0;
        err       <= 1'b0;
        core_hold <= 1'b1;
        busy      <= 1'b1;
      end
      if (accept) begin
        case (state)
          S_LEN_HI: len[15:8] <= in_data;
          S_LEN_LO: len[7:0]  <= in_data;
          S_DATA_HI: begin
            hi_byte <= in_data;
            csum    <= csum ^ in_data;
          end
          S_DATA_LO: begin
            csum      <= csum ^ in_data;
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= {hi_byte, in_data};
            wr_addr   <= wr_addr + ADDR_ONE;
            word_cnt  <= word_cnt + 16'd1;
          end
          S_CSUM: begin
            busy <= 1'b0;
            if (in_data == csum) begin
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
